// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the multiplier pipeline.
// Operand class enum, exponent bias and canonical special encodings.
package fp_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_cls_e;

  function automatic int fp_bias(input int ew);
    return (1 << (ew - 1)) - 1;
  endfunction

  // +inf: all-ones exponent, zero fraction, sign 0
  function automatic logic [63:0] fp_inf(input int ew, input int mw);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < ew; i++) r[mw+i] = 1'b1;
    return r;
  endfunction

  // Canonical quiet NaN: +inf pattern plus fraction MSB
  function automatic logic [63:0] fp_qnan(input int ew, input int mw);
    logic [63:0] r;
    r = fp_inf(ew, mw);
    r[mw-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised significand.
// Carry-out means the significand wrapped to 2.0 and needs renormalising.
module fp_round_rne #(
  parameter int SW = 24
) (
  input  logic [SW-1:0] sig,
  input  logic          guard,
  input  logic          sticky,
  output logic [SW-1:0] rsig,
  output logic          cout,
  output logic          inexact
);

  logic inc;

  // increment above half, or at exactly half when the LSB is odd
  always_comb begin
    inc = guard & (sticky | sig[0]);
    {cout, rsig} = {1'b0, sig} + (SW + 1)'(inc);
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage IEEE-754 style multiplier, flush-to-zero, RNE rounding.
// FP_MUL_PIPE_FLAGS_EN adds out_flags {invalid, overflow, underflow, inexact}.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result
`ifdef FP_MUL_PIPE_FLAGS_EN
  ,
  output logic [3:0]             out_flags
`endif
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int XW = EXP_W + 2;

  localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [W-1:0] INFW = W'(fp_inf(EXP_W, MAN_W));
  localparam logic signed [XW-1:0] BIAS = XW'(fp_bias(EXP_W));
  localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
  localparam logic signed [XW-1:0] EZERO = '0;

  function automatic fp_cls_e classify(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] f
  );
    if (e == '0) return ZERO;
    if (&e) return (f == '0) ? INF : NAN;
    return NORM;
  endfunction

  // stage enables: a stage loads when it is empty or drains onward
  logic en1, en2, en3;
  logic v1, v2;

  assign in_ready = out_ready || !out_valid;
  assign en3 = in_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;

  // ---- stage 1: classify, exponent sum, significand product
  logic                 sa, sb;
  logic [EXP_W-1:0]     ea, eb;
  logic [MAN_W-1:0]     fa, fb;
  fp_cls_e              ca, cb, k1_d;
  logic signed [XW-1:0] x1_d;
  logic [PW-1:0]        p1_d;

  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = in_b;
  assign ca = classify(ea, fa);
  assign cb = classify(eb, fb);
  assign x1_d = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
  assign p1_d = PW'({1'b1, fa}) * PW'({1'b1, fb});

  // special-case priority: NaN (incl. inf*0) over inf over zero
  always_comb begin
    if (ca == NAN || cb == NAN ||
        (ca == INF && cb == ZERO) ||
        (ca == ZERO && cb == INF))
      k1_d = NAN;
    else if (ca == INF || cb == INF)
      k1_d = INF;
    else if (ca == ZERO || cb == ZERO)
      k1_d = ZERO;
    else
      k1_d = NORM;
  end

  logic                 s1;
  fp_cls_e              k1;
  logic signed [XW-1:0] x1;
  logic [PW-1:0]        p1;

`ifdef FP_MUL_PIPE_FLAGS_EN
  logic inv1_d, inv1, inv2;
  assign inv1_d = (ca == NAN && !fa[MAN_W-1]) ||
                  (cb == NAN && !fb[MAN_W-1]) ||
                  (ca == INF && cb == ZERO) ||
                  (ca == ZERO && cb == INF);
`endif

  // stage 1 register: capture accepted operand pair
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      s1 <= 1'b0;
      k1 <= ZERO;
      x1 <= '0;
      p1 <= '0;
`ifdef FP_MUL_PIPE_FLAGS_EN
      inv1 <= 1'b0;
`endif
    end else if (en1) begin
      v1 <= in_valid && in_ready;
      s1 <= sa ^ sb;
      k1 <= k1_d;
      x1 <= x1_d;
      p1 <= p1_d;
`ifdef FP_MUL_PIPE_FLAGS_EN
      inv1 <= inv1_d;
`endif
    end
  end

  // ---- stage 2: normalise product, derive guard and sticky
  logic                 msb;
  logic [MAN_W:0]       sig2_d;
  logic                 g2_d, st2_d;
  logic signed [XW-1:0] x2_d;

  assign msb = p1[PW-1];
  assign x2_d = x1 + $signed({{(XW-1){1'b0}}, msb});

  // product lies in [1,4); a set MSB means shift right by one
  always_comb begin
    if (msb) begin
      sig2_d = p1[PW-1:MAN_W+1];
      g2_d   = p1[MAN_W];
      st2_d  = |p1[MAN_W-1:0];
    end else begin
      sig2_d = p1[PW-2:MAN_W];
      g2_d   = p1[MAN_W-1];
      st2_d  = |p1[MAN_W-2:0];
    end
  end

  logic                 s2, g2, st2;
  fp_cls_e              k2;
  logic signed [XW-1:0] x2;
  logic [MAN_W:0]       sig2;

  // stage 2 register: normalised significand and round bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      s2   <= 1'b0;
      k2   <= ZERO;
      x2   <= '0;
      sig2 <= '0;
      g2   <= 1'b0;
      st2  <= 1'b0;
`ifdef FP_MUL_PIPE_FLAGS_EN
      inv2 <= 1'b0;
`endif
    end else if (en2) begin
      v2   <= v1;
      s2   <= s1;
      k2   <= k1;
      x2   <= x2_d;
      sig2 <= sig2_d;
      g2   <= g2_d;
      st2  <= st2_d;
`ifdef FP_MUL_PIPE_FLAGS_EN
      inv2 <= inv1;
`endif
    end
  end

  // ---- stage 3: round, renormalise, range check, pack
  logic [MAN_W:0]       rsig;
  logic                 cout, rinx;
  logic signed [XW-1:0] e3;
  logic [MAN_W-1:0]     frac3;
  logic                 ovf3, unf3;
  logic [W-1:0]         res3;
  logic                 unused_hi;

  fp_round_rne #(
    .SW(MAN_W + 1)
  ) u_round (
    .sig     (sig2),
    .guard   (g2),
    .sticky  (st2),
    .rsig    (rsig),
    .cout    (cout),
    .inexact (rinx)
  );

  assign unused_hi = rsig[MAN_W];
  assign e3 = x2 + $signed({{(XW-1){1'b0}}, cout});
  assign frac3 = cout ? '0 : rsig[MAN_W-1:0];
  assign ovf3 = (k2 == NORM) && (e3 >= EMAX);
  assign unf3 = (k2 == NORM) && (e3 <= EZERO);

  // select special encoding or the packed finite result
  always_comb begin
    res3 = '0;
    unique case (k2)
      NAN:  res3 = QNAN;
      INF:  res3 = {s2, INFW[W-2:0]};
      ZERO: res3 = {s2, {(W-1){1'b0}}};
      default: begin
        if (ovf3)
          res3 = {s2, INFW[W-2:0]};
        else if (unf3)
          res3 = {s2, {(W-1){1'b0}}};
        else
          res3 = {s2, e3[EXP_W-1:0], frac3};
      end
    endcase
  end

`ifdef FP_MUL_PIPE_FLAGS_EN
  logic [3:0] fl3;
  assign fl3 = {inv2, ovf3, unf3,
                (k2 == NORM) && (rinx || ovf3 || unf3)};
`else
  logic unused_inx;
  assign unused_inx = rinx;
`endif

  // stage 3 register: the visible output slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef FP_MUL_PIPE_FLAGS_EN
      out_flags  <= '0;
`endif
    end else if (en3) begin
      out_valid  <= v2;
      out_result <= res3;
`ifdef FP_MUL_PIPE_FLAGS_EN
      out_flags  <= fl3;
`endif
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe (single precision).
// Expected results come from a remainder-based reference multiplier.
module tb_fp_mul_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
`ifdef FP_MUL_PIPE_FLAGS_EN
  logic [3:0]  out_flags;
`endif

  fp_mul_pipe #(
    .EXP_W(8),
    .MAN_W(23)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
`ifdef FP_MUL_PIPE_FLAGS_EN
    ,
    .out_flags  (out_flags)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nout = 0;
  int nin = 0;
  bit lat_chk = 0;
  bit saw_drop = 0;
  bit done = 0;
  logic [35:0] q[$];
  int tq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference: {flags, result}, flags = {inv, ovf, unf, inx}
  function automatic logic [35:0] ref_mul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic       s, na, nb, ia, ib, za, zb, sn, inx;
    logic [47:0] p, keep, rem, half;
    int         e, sh;
    logic [31:0] r;
    logic [3:0]  fl;
    s  = a[31] ^ b[31];
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    za = a[30:23] == 8'h00;
    zb = b[30:23] == 8'h00;
    sn = (na && !a[22]) || (nb && !b[22]);
    fl = 4'b0000;
    if (na || nb) begin
      r = 32'h7FC00000;
      fl = {sn, 3'b000};
    end else if ((ia && zb) || (za && ib)) begin
      r = 32'h7FC00000;
      fl = 4'b1000;
    end else if (ia || ib) begin
      r = {s, 8'hFF, 23'd0};
    end else if (za || zb) begin
      r = {s, 31'd0};
    end else begin
      p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      sh = p[47] ? 24 : 23;
      e = int'(a[30:23]) + int'(b[30:23]) - 127 + (p[47] ? 1 : 0);
      keep = p >> sh;
      rem = p & ((48'd1 << sh) - 48'd1);
      half = 48'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 48'd1;
      if (keep[24]) begin
        keep = keep >> 1;
        e = e + 1;
      end
      inx = rem != 0;
      if (e >= 255) begin
        r = {s, 8'hFF, 23'd0};
        fl = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'd0};
        fl = 4'b0011;
      end else begin
        r = {s, e[7:0], keep[22:0]};
        fl = {3'b000, inx};
      end
    end
    return {fl, r};
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] v;
    v = $urandom;
    if ($urandom_range(0, 1) == 1)
      v[30:23] = 8'($urandom_range(90, 165));
    return v;
  endfunction

  // caller sits just after a rising edge; returns likewise
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [35:0] e);
    int n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'(in_ready), 64'(1));
    end else begin
      q.push_back(e);
      tq.push_back(cyc);
      nin++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 64'(q.size()), 64'(0));
  endtask

  // monitor: pop scoreboard on every output transfer
  always @(negedge clk) begin : mon
    logic [35:0] e;
    int t;
    if (!rst && in_valid && !in_ready) saw_drop = 1;
    if (out_valid && out_ready) begin
      nout++;
      chk("sb_nonempty", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        t = tq.pop_front();
        chk("result", 64'(out_result), 64'(e[31:0]));
`ifdef FP_MUL_PIPE_FLAGS_EN
        chk("flags", 64'(out_flags), 64'(e[35:32]));
`endif
        if (lat_chk) chk("latency", 64'(cyc - t), 64'(3));
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t tab[13] = '{
    '{32'h40400000, 32'h40000000, 32'h40C00000, 4'b0000},
    '{32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000},
    '{32'h3F800800, 32'h3F800800, 32'h3F801000, 4'b0001},
    '{32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000},
    '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101},
    '{32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000},
    '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000},
    '{32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000},
    '{32'h00000000, 32'hC0A00000, 32'h80000000, 4'b0000},
    '{32'hFF800000, 32'hC0000000, 32'h7F800000, 4'b0000},
    '{32'h00800000, 32'h00800000, 32'h00000000, 4'b0011},
    '{32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000},
    '{32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'b0001}
  };

  logic [31:0] ra, rb;
  int nout0;

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_result", 64'(out_result), 64'(0));
`ifdef FP_MUL_PIPE_FLAGS_EN
    chk("rst_flags", 64'(out_flags), 64'(0));
`endif
    idle(2);
    rst = 1'b0;
    idle(1);
    chk("rdy_after_rst", 64'(in_ready), 64'(1));

    // directed vectors, no stall, latency checked
    lat_chk = 1;
    foreach (tab[i]) send(tab[i].a, tab[i].b, {tab[i].f, tab[i].r});
    idle(6);
    lat_chk = 0;
    drain();

    // 8 back-to-back with out_ready low in cycles 4..7
    saw_drop = 0;
    nout0 = nout;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          ra = gen();
          rb = gen();
          send(ra, rb, ref_mul(ra, rb));
        end
      end
      begin
        for (int k = 0; k < 12; k++) begin
          out_ready = !(k >= 4 && k <= 7);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stream_drop", 64'(saw_drop), 64'(1));
    chk("stream_count", 64'(nout - nout0), 64'(8));

    // random traffic with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          ra = gen();
          rb = gen();
          send(ra, rb, ref_mul(ra, rb));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = $urandom_range(0, 2) != 0;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("in_out_count", 64'(nout), 64'(nin));

    // reset with three operations in flight
    send(32'h40400000, 32'h40000000, 36'h040C00000);
    send(32'h3FC00000, 32'h3FC00000, 36'h040100000);
    send(32'h40000000, 32'h40000000, 36'h040800000);
    chk("pre_rst_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1'b1;
    q.delete();
    tq.delete();
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_ready", 64'(in_ready), 64'(1));
    chk("mid_rst_result", 64'(out_result), 64'(0));
`ifdef FP_MUL_PIPE_FLAGS_EN
    chk("mid_rst_flags", 64'(out_flags), 64'(0));
`endif
    idle(2);
    rst = 1'b0;
    nout0 = nout;
    idle(1);
    chk("post_rst_ready", 64'(in_ready), 64'(1));
    idle(8);
    chk("no_stale", 64'(nout - nout0), 64'(0));

    // pipeline still works after reset
    lat_chk = 1;
    send(32'h40400000, 32'h40000000, 36'h040C00000);
    idle(5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    chk("watchdog", 64'(0), 64'(1));
    $fatal(1, "watchdog expired");
  end

endmodule
